// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and external hold.
// Define IDEX_STALL_CNT_EN to add a 32-bit stall_cnt output counting effective stall cycles.
module id_ex_stage_reg #(
  parameter int size     = 31,
  parameter int reg_bits = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              flush,
  input  logic [reg_bits:0] d_rs,
  input  logic [reg_bits:0] d_rt,
  input  logic [reg_bits:0] d_rd,
  input  logic [size:0]     d_rdata1,
  input  logic [size:0]     d_rdata2,
  input  logic [size:0]     d_imm,
  input  logic [size:0]     d_pc4,
  input  logic [8:0]        d_ctrl,
  output logic [reg_bits:0] e_rs,
  output logic [reg_bits:0] e_rt,
  output logic [reg_bits:0] e_rd,
  output logic [size:0]     e_rdata1,
  output logic [size:0]     e_rdata2,
  output logic [size:0]     e_imm,
  output logic [size:0]     e_pc4,
  output logic [8:0]        e_ctrl,
  output logic              e_valid,
  output logic              stall
`ifdef IDEX_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  // Control word: {reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, reg_dst, alu_op[1:0]}
  localparam int MemReadBit = 6;

  logic [reg_bits:0] e_rs_q, e_rs_d;
  logic [reg_bits:0] e_rt_q, e_rt_d;
  logic [reg_bits:0] e_rd_q, e_rd_d;
  logic [size:0]     e_rdata1_q, e_rdata1_d;
  logic [size:0]     e_rdata2_q, e_rdata2_d;
  logic [size:0]     e_imm_q, e_imm_d;
  logic [size:0]     e_pc4_q, e_pc4_d;
  logic [8:0]        e_ctrl_q, e_ctrl_d;
  logic              e_valid_q, e_valid_d;

  logic load_use;
  logic bubble;
  logic load;

  // A load in execute whose target is read by decode; $0 is never a real dependency.
  assign load_use = e_valid_q & e_ctrl_q[MemReadBit] & (e_rt_q != '0) &
                    ((e_rt_q == d_rs) | (e_rt_q == d_rt));

  assign stall  = load_use & ~flush;
  assign bubble = flush | (~hold & stall);
  assign load   = ~flush & ~hold & ~stall;

  always_comb begin
    e_rs_d     = e_rs_q;
    e_rt_d     = e_rt_q;
    e_rd_d     = e_rd_q;
    e_rdata1_d = e_rdata1_q;
    e_rdata2_d = e_rdata2_q;
    e_imm_d    = e_imm_q;
    e_pc4_d    = e_pc4_q;
    e_ctrl_d   = e_ctrl_q;
    e_valid_d  = e_valid_q;
    if (load) begin
      e_rs_d     = d_rs;
      e_rt_d     = d_rt;
      e_rd_d     = d_rd;
      e_rdata1_d = d_rdata1;
      e_rdata2_d = d_rdata2;
      e_imm_d    = d_imm;
      e_pc4_d    = d_pc4;
      e_ctrl_d   = d_ctrl;
      e_valid_d  = 1'b1;
    end
    // Bubble data fields simply hold; only control and valid need clearing.
    if (bubble) begin
      e_ctrl_d  = '0;
      e_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_rs_q     <= '0;
      e_rt_q     <= '0;
      e_rd_q     <= '0;
      e_rdata1_q <= '0;
      e_rdata2_q <= '0;
      e_imm_q    <= '0;
      e_pc4_q    <= '0;
      e_ctrl_q   <= '0;
      e_valid_q  <= 1'b0;
    end else begin
      e_rs_q     <= e_rs_d;
      e_rt_q     <= e_rt_d;
      e_rd_q     <= e_rd_d;
      e_rdata1_q <= e_rdata1_d;
      e_rdata2_q <= e_rdata2_d;
      e_imm_q    <= e_imm_d;
      e_pc4_q    <= e_pc4_d;
      e_ctrl_q   <= e_ctrl_d;
      e_valid_q  <= e_valid_d;
    end
  end

  assign e_rs     = e_rs_q;
  assign e_rt     = e_rt_q;
  assign e_rd     = e_rd_q;
  assign e_rdata1 = e_rdata1_q;
  assign e_rdata2 = e_rdata2_q;
  assign e_imm    = e_imm_q;
  assign e_pc4    = e_pc4_q;
  assign e_ctrl   = e_ctrl_q;
  assign e_valid  = e_valid_q;

`ifdef IDEX_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Counts only stalls that actually inject a bubble; wraps naturally at 2^32.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall & ~hold & ~flush) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Decode-to-execute pipeline register for the 5-stage MIPS pipeline.
- Captures decoded operands, immediate, register specifiers and control bits; its registered outputs drive the execute-stage 2:1 select muxes (ALU operand B, destination register).
- Contains load-use hazard detection: it raises a stall to fetch/decode and inserts a bubble.
- Also accepts a branch flush and an external hold.

Parameters:
- size, 31, MSB index of data paths (data width = size+1).
- reg_bits, 4, MSB index of register specifiers (5-bit specifiers).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- hold  input  1  external freeze (memory busy); register keeps contents
- flush  input  1  branch taken; next state is bubble
- d_rs, d_rt, d_rd  input  reg_bits+1 each  decode register specifiers
- d_rdata1, d_rdata2  input  size+1 each  register file read data
- d_imm  input  size+1  sign-extended immediate
- d_pc4  input  size+1  PC+4 of decode instruction
- d_ctrl  input  9  {reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, reg_dst, alu_op[1:0]}
- e_rs, e_rt, e_rd  output  reg_bits+1 each  registered specifiers
- e_rdata1, e_rdata2, e_imm, e_pc4  output  size+1 each  registered data
- e_ctrl  output  9  registered control, same bit order
- e_valid  output  1  execute slot holds a real instruction
- stall  output  1  combinational; freeze PC and IF/ID this cycle

Behaviour:
- All state updates on the rising edge of clk. reset is synchronous, active-high.
- Reset: every output register is 0, including e_ctrl and e_valid. stall is then 0 because e_ctrl.mem_read is 0.
- Hazard equation: stall = e_valid & e_ctrl.mem_read & (e_rt != 0) & ((e_rt == d_rs) | (e_rt == d_rt)).
  - stall is purely combinational from registered state and decode inputs.
  - stall is forced to 0 while flush = 1.
- Next-state priority, highest first:
  1. reset: all zero.
  2. flush: bubble (e_ctrl = 0, e_valid = 0; data fields may load or hold, they are don't-care).
  3. hold: all fields keep their value. hold does not clear stall.
  4. stall: bubble.
  5. otherwise: load all d_* inputs; e_valid = 1.
- Latency: exactly 1 cycle from d_* to e_*.
- A load-use stall lasts exactly one cycle. After the bubble enters, e_ctrl.mem_read = 0, so stall deasserts and the dependent instruction loads on the following edge.
- Register $0: an e_rt of 0 never causes a stall.
- Simultaneous flush and stall: flush wins, one bubble, and stall output is 0.
- Simultaneous hold and flush: flush wins.
- A bubble sets reg_write and mem_write to 0, so it has no architectural effect.
- Reset mid-stall: the next cycle is all zero with stall = 0.

Optional Feature:
- Macro: IDEX_STALL_CNT_EN.
- When defined, the block adds:
  - Output stall_cnt (32 bits), cleared by reset.
  - stall_cnt increments on every edge where stall = 1, hold = 0 and flush = 0.
  - stall_cnt wraps from 0xFFFFFFFF to 0.
- When not defined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset: set all d_* to 0xA5A5A5A5 / 0x1FF and assert reset for 2 cycles. Required: all e_* = 0, e_valid = 0, stall = 0. Then release with d_rdata1 = 0x12345678. Required: e_rdata1 = 0x12345678 and e_valid = 1 one edge later.
- Load-use: load lw with d_rt = 5 (mem_read = 1). Next cycle present d_rs = 5. Required: stall = 1 that cycle, and e_ctrl = 0, e_valid = 0 after the edge. Then stall = 0 and the add loads on the next edge.
- $0 exemption: lw with rt = 0 followed by d_rs = 0. Required: stall stays 0 and there is no bubble.
- Flush vs stall: create the load-use condition and assert flush in the same cycle. Required: stall = 0, then after the edge e_ctrl = 0 and e_valid = 0. Hold: assert hold for 3 cycles with changing d_*. Required: e_* unchanged for those 3 cycles.
- Counter (IDEX_STALL_CNT_EN): run 3 separate load-use events and 1 flush-masked event. Required: stall_cnt = 3.
- Counter wrap: force stall_cnt to 0xFFFFFFFF, then trigger one stall. Required: stall_cnt = 0.
